// File: rtl/cell_fetch_sequencer_pkg.sv
// Shared constants and types for the text-mode cell fetch sequencer:
// cell-word bit layout, character-height range and FSM state encoding.
package cell_fetch_sequencer_pkg;

    localparam int CHAR_H_DEFAULT = 10;

    localparam int CHARINDEX_HI   = 7;
    localparam int CHARINDEX_LO   = 0;
    localparam int CHARHEIGHT_W   = 4;

    localparam int BIT_INVERT     = 8;
    localparam int BIT_UNDERLINE  = 9;
    localparam int BIT_XSIZE      = 10;
    localparam int BIT_YSIZE      = 11;
    localparam int BIT_YPART      = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] char_index;
        logic       invert;
        logic       underline;
        logic       xsize;
        logic       ysize;
        logic       ypart;
    } cell_attr_t;

    // Split a raw text-RAM word into the fields the generator consumes.
    function automatic cell_attr_t unpack_cell(input logic [15:0] w);
        cell_attr_t c;
        c.char_index = w[CHARINDEX_HI:CHARINDEX_LO];
        c.invert     = w[BIT_INVERT];
        c.underline  = w[BIT_UNDERLINE];
        c.xsize      = w[BIT_XSIZE];
        c.ysize      = w[BIT_YSIZE];
        c.ypart      = w[BIT_YPART];
        return c;
    endfunction

endpackage

// File: rtl/cell_fetch_sequencer_pixel_shifter.sv
// 8-bit pixel row shifter: parallel load, shift left, MSB is the current pixel.
module pixel_shifter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic       i_shift_en,
    input  logic [7:0] i_data,
    output logic       o_msb
);

    logic [7:0] r_sr;

    // Clear beats load beats shift so a frame restart always blanks the row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr <= 8'h00;
        end else if (i_clear) begin
            r_sr <= 8'h00;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift_en) begin
            r_sr <= {r_sr[6:0], 1'b0};
        end
    end

    assign o_msb = r_sr[7];

endmodule

// File: rtl/cell_fetch_sequencer.sv
// Per-scanline character-cell fetch sequencer.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for line_start
// FETCH | 8-phase cell loop over all columns of the current scanline
// DRAIN | last cell's 8 pixels shift out, then row/scanline advance
// DONE  | every scanline of the frame emitted; only frame_start leaves
module cell_fetch_sequencer
    import cell_fetch_sequencer_pkg::*;
#(
    parameter int COLUMNS = 80,
    parameter int ROWS    = 48,
    parameter int CHAR_H  = CHAR_H_DEFAULT,
    parameter int ADDR_W  = 12
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    frame_start,
    input  logic                    line_start,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd,
    input  logic [15:0]             mem_data,
    output logic [7:0]              gen_char_index,
    output logic [CHARHEIGHT_W-1:0] gen_ychar,
    output logic                    gen_xsize,
    output logic                    gen_ysize,
    output logic                    gen_xpart,
    output logic                    gen_ypart,
    output logic                    gen_underline,
    output logic                    gen_invert,
    input  logic [7:0]              gen_row_pixels,
    output logic                    pixel,
    output logic                    pixel_active,
    output logic                    overrun
);

    localparam int COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int ROW_W = $clog2(ROWS + 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_phase;
    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic [CHARHEIGHT_W-1:0] r_ychar;
    logic [ADDR_W-1:0]       r_row_base;
    logic                    r_pend_valid;
    cell_attr_t              r_pend;
    cell_attr_t              r_gen;
    logic                    r_gen_xpart;
    logic                    r_active;
    logic                    r_overrun;

    logic                    w_last_phase;
    logic                    w_last_col;
    logic                    w_last_ychar;
    logic                    w_last_row;
    logic                    w_line_end;
    logic                    w_load;
    logic                    w_latch;
    logic                    w_busy;
    logic                    w_shift_msb;
    cell_attr_t              w_word;

    assign w_last_phase = (r_phase == 3'd7);
    assign w_last_col   = (r_col == COL_W'(COLUMNS - 1));
    assign w_last_ychar = (r_ychar == CHARHEIGHT_W'(CHAR_H - 1));
    assign w_last_row   = (r_row == ROW_W'(ROWS - 1));
    assign w_line_end   = (r_state == ST_DRAIN) && w_last_phase;
    assign w_load       = (r_state == ST_FETCH) && w_last_phase;
    assign w_latch      = (r_state == ST_FETCH) && (r_phase == 3'd1);
    assign w_busy       = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign w_word       = unpack_cell(mem_data);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; frame_start overrides everything, including line_start.
    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (line_start) w_state_nxt = ST_FETCH;
                ST_FETCH: if (w_last_phase && w_last_col) w_state_nxt = ST_DRAIN;
                ST_DRAIN: if (w_last_phase)
                              w_state_nxt = (w_last_ychar && w_last_row) ? ST_DONE : ST_IDLE;
                ST_DONE:  w_state_nxt = ST_DONE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Phase and column counters; the 3-bit phase wraps on its own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= 3'd0;
            r_col   <= '0;
        end else if (frame_start || ((r_state == ST_IDLE) && line_start)) begin
            r_phase <= 3'd0;
            r_col   <= '0;
        end else if (r_state == ST_FETCH) begin
            r_phase <= r_phase + 3'd1;
            if (w_last_phase) begin
                r_col <= w_last_col ? '0 : r_col + COL_W'(1);
            end
        end else if (r_state == ST_DRAIN) begin
            r_phase <= r_phase + 3'd1;
        end
    end

    // Scanline / text-row advance; row_base is accumulated instead of multiplied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ychar    <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (frame_start) begin
            r_ychar    <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (w_line_end) begin
            if (w_last_ychar) begin
                r_ychar    <= '0;
                r_row      <= r_row + ROW_W'(1);
                r_row_base <= r_row_base + ADDR_W'(COLUMNS);
            end else begin
                r_ychar <= r_ychar + CHARHEIGHT_W'(1);
            end
        end
    end

    // Double-width resolution: a pending first half supplies the next cell,
    // whose own RAM word is discarded. Pending never survives a line end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
            r_gen        <= '0;
            r_gen_xpart  <= 1'b0;
        end else if (frame_start || w_line_end) begin
            r_pend_valid <= 1'b0;
        end else if (w_latch) begin
            if (r_pend_valid) begin
                r_gen        <= r_pend;
                r_gen_xpart  <= 1'b1;
                r_pend_valid <= 1'b0;
            end else begin
                r_gen        <= w_word;
                r_gen_xpart  <= 1'b0;
                r_pend       <= w_word;
                r_pend_valid <= w_word.xsize;
            end
        end
    end

    // Pixel window opens on the first row load and closes when the drain ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
        end else if (frame_start || w_line_end) begin
            r_active <= 1'b0;
        end else if (w_load) begin
            r_active <= 1'b1;
        end
    end

    // Sticky overrun: a new line requested before the previous one finished.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (frame_start) begin
            r_overrun <= 1'b0;
        end else if (line_start && w_busy) begin
            r_overrun <= 1'b1;
        end
    end

    pixel_shifter u_shifter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (frame_start),
        .i_load     (w_load),
        .i_shift_en (r_active),
        .i_data     (gen_row_pixels),
        .o_msb      (w_shift_msb)
    );

    assign mem_rd         = (r_state == ST_FETCH) && (r_phase == 3'd0);
    assign mem_addr       = r_row_base + ADDR_W'(r_col);
    assign gen_char_index = r_gen.char_index;
    assign gen_ychar      = r_ychar;
    assign gen_xsize      = r_gen.xsize;
    assign gen_ysize      = r_gen.ysize;
    assign gen_xpart      = r_gen_xpart;
    assign gen_ypart      = r_gen.ypart;
    assign gen_underline  = r_gen.underline;
    assign gen_invert     = r_gen.invert;
    assign pixel          = r_active & w_shift_msb;
    assign pixel_active   = r_active;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_cell_fetch_sequencer.sv
// Scoreboard bench for cell_fetch_sequencer: random text RAM, a behavioural
// line model that queues expected fetches and pixels, and two monitors.
// ROWS is reduced so a whole frame (and the DONE state) fits a short run.
module tb_cell_fetch_sequencer;

    localparam int COLUMNS = 80;
    localparam int ROWS    = 4;
    localparam int CHAR_H  = 10;
    localparam int ADDR_W  = 12;
    localparam int BIG     = 1000000;

    logic              clk;
    logic              reset_n;
    logic              frame_start;
    logic              line_start;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_data = 16'h0000;
    logic [7:0]        gen_char_index;
    logic [3:0]        gen_ychar;
    logic              gen_xsize, gen_ysize, gen_xpart, gen_ypart;
    logic              gen_underline, gen_invert;
    logic [7:0]        gen_row_pixels;
    logic              pixel, pixel_active, overrun;

    cell_fetch_sequencer #(
        .COLUMNS (COLUMNS),
        .ROWS    (ROWS),
        .CHAR_H  (CHAR_H),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .line_start     (line_start),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .gen_char_index (gen_char_index),
        .gen_ychar      (gen_ychar),
        .gen_xsize      (gen_xsize),
        .gen_ysize      (gen_ysize),
        .gen_xpart      (gen_xpart),
        .gen_ypart      (gen_ypart),
        .gen_underline  (gen_underline),
        .gen_invert     (gen_invert),
        .gen_row_pixels (gen_row_pixels),
        .pixel          (pixel),
        .pixel_active   (pixel_active),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Text RAM: one-cycle read latency.
    logic [15:0] ram [0:4095];
    always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

    // Character generator stand-in: any fixed mix of every selection input.
    function automatic logic [7:0] gen_fn(input logic [7:0] c, input logic [3:0] y,
                                          input logic xs, input logic ys, input logic xp,
                                          input logic yp, input logic ul, input logic inv);
        return c ^ 8'hE4 ^ {y, xp, inv, ul, 1'b0} ^ {xs, ys, yp, 5'b00000};
    endfunction

    assign gen_row_pixels = gen_fn(gen_char_index, gen_ychar, gen_xsize, gen_ysize,
                                   gen_xpart, gen_ypart, gen_underline, gen_invert);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        bit                chk_gen;
        logic [17:0]       gen;
    } cell_exp_t;

    cell_exp_t q_cell[$];
    bit        q_pix[$];
    int        m_ychar, m_row;
    bit        m_done;

    task automatic model_frame();
        m_ychar = 0;
        m_row   = 0;
        m_done  = 1'b0;
    endtask

    // Expected output of one scanline. `cut` = cycles after line_start that
    // the line is allowed to run before being aborted (BIG = runs to the end).
    task automatic model_line(input int cut);
        logic [15:0] w, src, pend;
        bit          pend_v, xp;
        logic [7:0]  px;
        cell_exp_t   e;
        if (m_done) return;
        pend_v = 1'b0;
        pend   = 16'h0;
        for (int c = 0; c < COLUMNS; c++) begin
            w = ram[m_row * COLUMNS + c];
            if (pend_v) begin
                src = pend; xp = 1'b1; pend_v = 1'b0;
            end else begin
                src = w; xp = 1'b0;
                if (w[10]) begin pend = w; pend_v = 1'b1; end
            end
            e.addr    = ADDR_W'(m_row * COLUMNS + c);
            e.chk_gen = (3 + 8 * c <= cut);
            e.gen     = {src[7:0], 4'(m_ychar), src[10], src[11], xp, src[12], src[9], src[8]};
            px = gen_fn(src[7:0], 4'(m_ychar), src[10], src[11], xp, src[12], src[9], src[8]);
            if (1 + 8 * c <= cut) q_cell.push_back(e);
            for (int k = 0; k < 8; k++)
                if (9 + 8 * c + k <= cut) q_pix.push_back(px[7 - k]);
        end
        if (cut >= 8 * COLUMNS + 8) begin
            if (m_ychar == CHAR_H - 1) begin
                m_ychar = 0;
                if (m_row == ROWS - 1) m_done = 1'b1;
                else m_row++;
            end else begin
                m_ychar++;
            end
        end
    endtask

    // Fetch monitor: address on every read strobe, generator inputs two cycles later.
    initial begin : mon_cell
        cell_exp_t e;
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                if (q_cell.size() == 0) begin
                    check("unexpected_mem_rd", mem_rd, 0);
                end else begin
                    e = q_cell.pop_front();
                    check("mem_addr", mem_addr, e.addr);
                    if (e.chk_gen) begin
                        repeat (2) @(negedge clk);
                        check("gen_fields", {gen_char_index, gen_ychar, gen_xsize, gen_ysize,
                                             gen_xpart, gen_ypart, gen_underline, gen_invert}, e.gen);
                    end
                end
            end
        end
    end

    // Pixel monitor: one expected bit per active cycle; pixel must be 0 otherwise.
    initial begin : mon_pix
        forever begin
            @(negedge clk);
            if (pixel_active === 1'b1) begin
                if (q_pix.size() == 0) check("unexpected_pixel_active", pixel_active, 0);
                else check("pixel", pixel, q_pix.pop_front());
            end else if (pixel !== 1'b0) begin
                check("pixel_gated", pixel, 0);
            end
        end
    end

    task automatic pulse_line();
        @(negedge clk) line_start = 1'b1;
        @(negedge clk) line_start = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    function automatic logic [63:0] all_outputs();
        return {mem_addr, mem_rd, gen_char_index, gen_ychar, gen_xsize, gen_ysize, gen_xpart,
                gen_ypart, gen_underline, gen_invert, pixel, pixel_active, overrun};
    endfunction

    initial begin
        reset_n     = 1'b0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom) & 16'h1FFF;
        ram[0]  = 16'h0041;
        ram[2]  = 16'h0030;
        ram[3]  = 16'h0442;
        ram[4]  = 16'h0020;
        ram[5]  = 16'h0443;
        ram[77] = 16'h0031;
        ram[78] = 16'h0032;
        ram[79] = 16'h0444;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_mem_rd", mem_rd, 0);

        // Full frame with random line periods at or above the minimum.
        pulse_frame();
        model_frame();
        for (int l = 0; l < ROWS * CHAR_H; l++) begin
            model_line(BIG);
            pulse_line();
            repeat (647 + $urandom_range(0, 6)) @(negedge clk);
        end
        check("no_overrun_at_min_period", overrun, 0);
        check("frame_cell_queue_empty", q_cell.size(), 0);
        check("frame_pixel_queue_empty", q_pix.size(), 0);

        // Frame exhausted: the next line_start must produce nothing.
        model_line(BIG);
        pulse_line();
        repeat (700) @(negedge clk);
        check("done_no_overrun", overrun, 0);
        check("done_pixel_active", pixel_active, 0);

        // Overrun: second line_start 100 cycles into a line.
        pulse_frame();
        model_frame();
        check("overrun_cleared_by_frame", overrun, 0);
        model_line(BIG);
        pulse_line();
        repeat (98) @(negedge clk);
        pulse_line();
        check("overrun_set", overrun, 1);
        repeat (600) @(negedge clk);
        check("overrun_sticky", overrun, 1);
        check("overrun_pixel_queue_empty", q_pix.size(), 0);
        pulse_frame();
        model_frame();
        check("overrun_clear", overrun, 0);

        // frame_start 300 cycles into a line aborts it.
        model_line(300);
        pulse_line();
        repeat (298) @(negedge clk);
        pulse_frame();
        model_frame();
        check("active_after_frame", pixel_active, 0);
        check("abort_cell_queue_empty", q_cell.size(), 0);
        check("abort_pixel_queue_empty", q_pix.size(), 0);
        repeat (5) @(negedge clk);
        model_line(BIG);
        pulse_line();
        repeat (660) @(negedge clk);
        check("restart_cell_queue_empty", q_cell.size(), 0);
        check("restart_pixel_queue_empty", q_pix.size(), 0);

        // Asynchronous reset 200 cycles into a line.
        model_line(200);
        pulse_line();
        repeat (199) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", all_outputs(), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_frame();
        repeat (5) @(negedge clk);
        check("reset_cell_queue_empty", q_cell.size(), 0);
        check("reset_pixel_queue_empty", q_pix.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
